// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the entry record for the reorder buffer, dispatcher and rename table.
package reorder_buffer_pkg;

   localparam int ROB_WIDTH_DEF = 3;
   localparam int REG_ID_W      = 5;
   localparam int XLEN          = 32;

   // One in-flight instruction: allocated, result captured, destination register
   typedef struct packed {
      logic                valid;
      logic                ready;
      logic [REG_ID_W-1:0] rd;
      logic [XLEN-1:0]     val;
   } rob_entry_t;

   localparam rob_entry_t ROB_ENTRY_EMPTY = '{valid: 1'b0, ready: 1'b0, rd: '0, val: '0};

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup for the dispatcher: tag -> ready/value, forwarding a same-cycle writeback.
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
   input  logic [ROB_WIDTH-1:0]                 i_query_id,
   input  logic                                 i_wb_valid,
   input  logic [ROB_WIDTH-1:0]                 i_wb_rob_id,
   input  logic [XLEN-1:0]                      i_wb_val,
   input  logic [(2**ROB_WIDTH)-1:0]            i_valid,
   input  logic [(2**ROB_WIDTH)-1:0]            i_ready,
   input  logic [(2**ROB_WIDTH)-1:0][XLEN-1:0]  i_val,
   output logic                                 o_rdy,
   output logic [XLEN-1:0]                      o_val
);

   logic            w_sel_valid;
   logic            w_sel_ready;
   logic [XLEN-1:0] w_sel_val;
   logic            w_bypass;

   // Select the queried entry; a dead entry reports nothing, a live one prefers the bus value
   always_comb begin
      w_sel_valid = i_valid[i_query_id];
      w_sel_ready = i_ready[i_query_id];
      w_sel_val   = i_val[i_query_id];
      w_bypass    = i_wb_valid && (i_wb_rob_id == i_query_id) && w_sel_valid;
      o_rdy       = 1'b0;
      o_val       = '0;
      if (w_sel_valid) begin
         o_rdy = w_sel_ready | w_bypass;
         o_val = w_bypass ? i_wb_val : w_sel_val;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer feeding RegisterFile: allocate, capture writebacks, commit the head.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 flush_in,
   input  logic                 issue_valid,
   input  logic [REG_ID_W-1:0]  issue_rd,
   output logic [ROB_WIDTH-1:0] issue_rob_id,
   output logic                 rob_full,
   input  logic                 wb_valid,
   input  logic [ROB_WIDTH-1:0] wb_rob_id,
   input  logic [XLEN-1:0]      wb_val,
   input  logic [ROB_WIDTH-1:0] query_id1,
   input  logic [ROB_WIDTH-1:0] query_id2,
   output logic                 query_rdy1,
   output logic [XLEN-1:0]      query_val1,
   output logic                 query_rdy2,
   output logic [XLEN-1:0]      query_val2,
   output logic [REG_ID_W-1:0]  set_reg_id,
   output logic [XLEN-1:0]      set_val,
   output logic                 commit_valid,
   output logic [ROB_WIDTH-1:0] commit_rob_id
);

   localparam int DEPTH = 2 ** ROB_WIDTH;
   localparam logic [ROB_WIDTH-1:0] PTR_ONE  = ROB_WIDTH'(1);
   localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
   localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(DEPTH);

   rob_entry_t            r_entry [DEPTH];
   logic [ROB_WIDTH-1:0]  r_head;
   logic [ROB_WIDTH-1:0]  r_tail;
   logic [ROB_WIDTH:0]    r_count;
   logic [REG_ID_W-1:0]   r_set_reg_id;
   logic [XLEN-1:0]       r_set_val;
   logic                  r_commit_valid;
   logic [ROB_WIDTH-1:0]  r_commit_rob_id;

   logic                         w_full;
   logic                         w_issue;
   logic                         w_commit;
   logic                         w_wb;
   logic [DEPTH-1:0]             w_valid_vec;
   logic [DEPTH-1:0]             w_ready_vec;
   logic [DEPTH-1:0][XLEN-1:0]   w_val_vec;

   // Decide this edge's events from registered state only; full uses the pre-edge count
   always_comb begin
      w_full   = (r_count == CNT_FULL);
      w_issue  = issue_valid && !w_full;
      w_commit = r_entry[r_head].valid && r_entry[r_head].ready;
      w_wb     = wb_valid && r_entry[wb_rob_id].valid;
   end

   // Flatten entry fields so each query port can index them as plain vectors
   always_comb begin
      w_valid_vec = '0;
      w_ready_vec = '0;
      w_val_vec   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_valid_vec[i] = r_entry[i].valid;
         w_ready_vec[i] = r_entry[i].ready;
         w_val_vec[i]   = r_entry[i].val;
      end
   end

   // Entry storage: writeback marks ready, commit clears head, issue claims tail; flush wipes all
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= ROB_ENTRY_EMPTY;
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_entry[i] <= ROB_ENTRY_EMPTY;
            end
         end else begin
            if (w_wb) begin
               r_entry[wb_rob_id].ready <= 1'b1;
               r_entry[wb_rob_id].val   <= wb_val;
            end
            if (w_commit) begin
               r_entry[r_head] <= ROB_ENTRY_EMPTY;
            end
            if (w_issue) begin
               r_entry[r_tail] <= '{valid: 1'b1, ready: 1'b0, rd: issue_rd, val: '0};
            end
         end
      end
   end

   // Head/tail pointers wrap naturally; occupancy nets out a simultaneous issue and commit
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_commit) begin
               r_head <= r_head + PTR_ONE;
            end
            if (w_issue) begin
               r_tail <= r_tail + PTR_ONE;
            end
            case ({w_issue, w_commit})
               2'b10:   r_count <= r_count + CNT_ONE;
               2'b01:   r_count <= r_count - CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Commit port to RegisterFile; stall edges leave it untouched so each write lands once
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_set_reg_id    <= '0;
         r_set_val       <= '0;
         r_commit_valid  <= 1'b0;
         r_commit_rob_id <= '0;
      end else if (rdy_in) begin
         if (!flush_in && w_commit) begin
            r_set_reg_id    <= r_entry[r_head].rd;
            r_set_val       <= r_entry[r_head].val;
            r_commit_valid  <= 1'b1;
            r_commit_rob_id <= r_head;
         end else begin
            r_set_reg_id   <= '0;
            r_commit_valid <= 1'b0;
         end
      end
   end

   assign issue_rob_id  = r_tail;
   assign rob_full      = w_full;
   assign set_reg_id    = r_set_reg_id;
   assign set_val       = r_set_val;
   assign commit_valid  = r_commit_valid;
   assign commit_rob_id = r_commit_rob_id;

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query1 (
      .i_query_id  (query_id1),
      .i_wb_valid  (wb_valid),
      .i_wb_rob_id (wb_rob_id),
      .i_wb_val    (wb_val),
      .i_valid     (w_valid_vec),
      .i_ready     (w_ready_vec),
      .i_val       (w_val_vec),
      .o_rdy       (query_rdy1),
      .o_val       (query_val1)
   );

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query2 (
      .i_query_id  (query_id2),
      .i_wb_valid  (wb_valid),
      .i_wb_rob_id (wb_rob_id),
      .i_wb_val    (wb_val),
      .i_valid     (w_valid_vec),
      .i_ready     (w_ready_vec),
      .i_val       (w_val_vec),
      .o_rdy       (query_rdy2),
      .o_val       (query_val2)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits queued up front, a monitor retires them.
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush_in;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_rob_id;
   logic        rob_full;
   logic        wb_valid;
   logic [2:0]  wb_rob_id;
   logic [31:0] wb_val;
   logic [2:0]  query_id1;
   logic [2:0]  query_id2;
   logic        query_rdy1;
   logic [31:0] query_val1;
   logic        query_rdy2;
   logic [31:0] query_val2;
   logic [4:0]  set_reg_id;
   logic [31:0] set_val;
   logic        commit_valid;
   logic [2:0]  commit_rob_id;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [2:0]  tag;
   } exp_t;

   exp_t expQ[$];
   int   totalCnt = 0;
   int   badCnt   = 0;

   reorder_buffer #(.ROB_WIDTH(3)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .flush_in      (flush_in),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .issue_rob_id  (issue_rob_id),
      .rob_full      (rob_full),
      .wb_valid      (wb_valid),
      .wb_rob_id     (wb_rob_id),
      .wb_val        (wb_val),
      .query_id1     (query_id1),
      .query_id2     (query_id2),
      .query_rdy1    (query_rdy1),
      .query_val1    (query_val1),
      .query_rdy2    (query_rdy2),
      .query_val2    (query_val2),
      .set_reg_id    (set_reg_id),
      .set_val       (set_val),
      .commit_valid  (commit_valid),
      .commit_rob_id (commit_rob_id)
   );

   // 10-unit clock
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCnt++;
      if (actual !== expected) begin
         badCnt++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic [4:0] rd, input logic [31:0] val, input logic [2:0] tag);
      expQ.push_back('{rd: rd, val: val, tag: tag});
   endtask

   // Drive one cycle of issue/writeback, then release the strobes
   task automatic applyStimulus(input logic iv, input logic [4:0] rd,
                                input logic wv, input logic [2:0] wid, input logic [31:0] wval);
      issue_valid = iv;
      issue_rd    = rd;
      wb_valid    = wv;
      wb_rob_id   = wid;
      wb_val      = wval;
      @(posedge clk_in);
      @(negedge clk_in);
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk_in);
         @(negedge clk_in);
      end
   endtask

   task automatic waitDrain(input int budget);
      int k;
      k = 0;
      while (expQ.size() != 0 && k < budget) begin
         @(posedge clk_in);
         @(negedge clk_in);
         k++;
      end
      checkOutput("drain pending", expQ.size(), 0);
   endtask

   // Monitor: every commit registered on a live edge must match the oldest expected retirement
   initial begin
      logic edgeRdy;
      logic edgeRst;
      exp_t e;
      forever begin
         @(posedge clk_in);
         edgeRdy = rdy_in;
         edgeRst = rst_in;
         #1;
         if (edgeRst === 1'b1 && rst_in === 1'b1 && edgeRdy === 1'b1 && commit_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected commit tag", {29'd0, commit_rob_id}, 32'hFFFF_FFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput("commit rd", {27'd0, set_reg_id}, {27'd0, e.rd});
               checkOutput("commit val", set_val, e.val);
               checkOutput("commit tag", {29'd0, commit_rob_id}, {29'd0, e.tag});
            end
         end
      end
   end

   // Hard time limit so a wedged design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_in      = 1'b0;
      rdy_in      = 1'b1;
      flush_in    = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      wb_valid    = 1'b0;
      wb_rob_id   = '0;
      wb_val      = '0;
      query_id1   = '0;
      query_id2   = '0;

      idleCycles(2);
      checkOutput("reset issue_rob_id", {29'd0, issue_rob_id}, 0);
      checkOutput("reset rob_full", {31'd0, rob_full}, 0);
      checkOutput("reset commit_valid", {31'd0, commit_valid}, 0);
      rst_in = 1'b1;
      idleCycles(1);

      $display("[TB] in-order commit of out-of-order writebacks");
      applyStimulus(1'b1, 5'd5, 1'b0, 3'd0, 32'h0);
      applyStimulus(1'b1, 5'd6, 1'b0, 3'd0, 32'h0);
      applyStimulus(1'b1, 5'd7, 1'b0, 3'd0, 32'h0);
      checkOutput("three issued tail", {29'd0, issue_rob_id}, 3);
      pushExp(5'd5, 32'h11, 3'd0);
      pushExp(5'd6, 32'h22, 3'd1);
      pushExp(5'd7, 32'h33, 3'd2);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd2, 32'h33);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'h22);
      checkOutput("no commit before head ready", {31'd0, commit_valid}, 0);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'h11);
      for (int i = 0; i < 3; i++) begin
         idleCycles(1);
         checkOutput("consecutive commit", {31'd0, commit_valid}, 1);
      end
      waitDrain(4);

      $display("[TB] writeback bypass on query port");
      applyStimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'h0);
      query_id1 = 3'd3;
      #1;
      checkOutput("query pending rdy", {31'd0, query_rdy1}, 0);
      wb_valid  = 1'b1;
      wb_rob_id = 3'd3;
      wb_val    = 32'hDEAD;
      query_id2 = 3'd4;
      #1;
      checkOutput("bypass rdy1", {31'd0, query_rdy1}, 1);
      checkOutput("bypass val1", query_val1, 32'hDEAD);
      checkOutput("invalid rdy2", {31'd0, query_rdy2}, 0);
      checkOutput("invalid val2", query_val2, 0);
      pushExp(5'd9, 32'hDEAD, 3'd3);
      @(posedge clk_in);
      @(negedge clk_in);
      wb_valid  = 1'b0;
      query_id2 = 3'd3;
      #1;
      checkOutput("stored rdy2", {31'd0, query_rdy2}, 1);
      checkOutput("stored val2", query_val2, 32'hDEAD);
      waitDrain(4);

      $display("[TB] asynchronous reset mid-run");
      applyStimulus(1'b1, 5'd10, 1'b0, 3'd0, 32'h0);
      pushExp(5'd10, 32'h1234, 3'd4);
      applyStimulus(1'b1, 5'd11, 1'b1, 3'd4, 32'h1234);
      idleCycles(1);
      checkOutput("pre-reset set_reg_id", {27'd0, set_reg_id}, 10);
      checkOutput("pre-reset issue_rob_id", {29'd0, issue_rob_id}, 6);
      #2;
      rst_in = 1'b0;
      #1;
      checkOutput("async set_reg_id", {27'd0, set_reg_id}, 0);
      checkOutput("async set_val", set_val, 0);
      checkOutput("async commit_valid", {31'd0, commit_valid}, 0);
      checkOutput("async commit_rob_id", {29'd0, commit_rob_id}, 0);
      checkOutput("async issue_rob_id", {29'd0, issue_rob_id}, 0);
      checkOutput("async rob_full", {31'd0, rob_full}, 0);
      checkOutput("drained before reset", expQ.size(), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idleCycles(1);

      $display("[TB] fill, full stall, issue alongside commit");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0);
         if (i == 6) checkOutput("seven entries not full", {31'd0, rob_full}, 0);
      end
      checkOutput("eight entries full", {31'd0, rob_full}, 1);
      checkOutput("tail wrapped", {29'd0, issue_rob_id}, 0);
      applyStimulus(1'b1, 5'd20, 1'b0, 3'd0, 32'h0);
      checkOutput("ninth ignored tail", {29'd0, issue_rob_id}, 0);
      checkOutput("ninth ignored full", {31'd0, rob_full}, 1);
      pushExp(5'd1, 32'hA0, 3'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'hA0);
      pushExp(5'd2, 32'hA1, 3'd1);
      applyStimulus(1'b1, 5'd21, 1'b1, 3'd1, 32'hA1);
      checkOutput("full commit drops issue tail", {29'd0, issue_rob_id}, 0);
      checkOutput("full commit drops issue full", {31'd0, rob_full}, 0);
      pushExp(5'd3, 32'hA2, 3'd2);
      applyStimulus(1'b1, 5'd21, 1'b1, 3'd2, 32'hA2);
      checkOutput("issue+commit tail", {29'd0, issue_rob_id}, 1);
      checkOutput("issue+commit count kept", {31'd0, rob_full}, 0);
      applyStimulus(1'b1, 5'd22, 1'b0, 3'd0, 32'h0);
      checkOutput("second issue+commit tail", {29'd0, issue_rob_id}, 2);
      checkOutput("second issue+commit full", {31'd0, rob_full}, 0);
      applyStimulus(1'b1, 5'd23, 1'b0, 3'd0, 32'h0);
      checkOutput("refill tail", {29'd0, issue_rob_id}, 3);
      checkOutput("refill full", {31'd0, rob_full}, 1);
      waitDrain(2);

      $display("[TB] stall holds a commit without repeating it");
      pushExp(5'd4, 32'hB3, 3'd3);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd3, 32'hB3);
      idleCycles(1);
      checkOutput("commit before stall rd", {27'd0, set_reg_id}, 4);
      checkOutput("commit before stall full", {31'd0, rob_full}, 0);
      rdy_in    = 1'b0;
      wb_valid  = 1'b1;
      wb_rob_id = 3'd4;
      wb_val    = 32'hB4;
      for (int i = 0; i < 3; i++) begin
         idleCycles(1);
         checkOutput("stall set_reg_id", {27'd0, set_reg_id}, 4);
         checkOutput("stall commit_valid", {31'd0, commit_valid}, 1);
         checkOutput("stall commit_rob_id", {29'd0, commit_rob_id}, 3);
         checkOutput("stall tail", {29'd0, issue_rob_id}, 3);
      end
      rdy_in   = 1'b1;
      wb_valid = 1'b0;
      idleCycles(1);
      checkOutput("post-stall no commit", {31'd0, commit_valid}, 0);
      checkOutput("post-stall set_reg_id", {27'd0, set_reg_id}, 0);
      checkOutput("stall write count", expQ.size(), 0);

      $display("[TB] flush with concurrent issue and writeback");
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd4, 32'hC4);
      flush_in = 1'b1;
      applyStimulus(1'b1, 5'd25, 1'b1, 3'd5, 32'hC5);
      flush_in  = 1'b0;
      query_id1 = 3'd4;
      query_id2 = 3'd5;
      #1;
      checkOutput("flush rob_full", {31'd0, rob_full}, 0);
      checkOutput("flush tail", {29'd0, issue_rob_id}, 0);
      checkOutput("flush set_reg_id", {27'd0, set_reg_id}, 0);
      checkOutput("flush commit_valid", {31'd0, commit_valid}, 0);
      checkOutput("flush query_rdy1", {31'd0, query_rdy1}, 0);
      checkOutput("flush query_val1", query_val1, 0);
      checkOutput("flush query_rdy2", {31'd0, query_rdy2}, 0);
      idleCycles(5);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'hEE);
      applyStimulus(1'b1, 5'd26, 1'b0, 3'd0, 32'h0);
      query_id1 = 3'd0;
      #1;
      checkOutput("wb to empty ignored", {31'd0, query_rdy1}, 0);
      pushExp(5'd26, 32'hD0, 3'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'hD0);
      waitDrain(4);
      idleCycles(2);
      checkOutput("final queue empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
